// File: rtl/alu_seq_legv8.sv
// Registered LEGv8-style ALU of width N: single-cycle logic/add/shift ops plus a
// fixed-latency shift-add multiplier, with a start/busy/done handshake.
module alu_seq_legv8 #(
   parameter int N = 64
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [4:0]   FS,
   input  logic         C0,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] F,
   output logic [3:0]   status
);
   localparam int SW = $clog2(N);
   localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_LSL = 3'b100;
   localparam logic [2:0] OP_LSR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_ASR = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   // Handshake: a request is taken on a rising edge with start=1 while busy=0;
   // done pulses for one cycle after the edge that wrote F/status.
   state_t         state_q, state_d;
   logic [N-1:0]   f_q, f_d;
   logic [3:0]     status_q, status_d;
   logic           done_q, done_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [N-1:0]   acc_q, acc_d;
   logic [SW-1:0]  cnt_q, cnt_d;

   logic [2:0]     op;
   logic [N-1:0]   as_s, bs_s;
   logic [SW-1:0]  sh;
   logic [N:0]     sum_ext;
   logic [N-1:0]   alu_res;
   logic           alu_c, alu_v;
   logic [N-1:0]   acc_step;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         f_q      <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         status_q <= status_d;
         done_q   <= done_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && op == OP_MUL) state_d = S_MUL;
         S_MUL:  if (cnt_q == CNT_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == S_MUL);
      done   = done_q;
      F      = f_q;
      status = status_q;
   end

   // Combinational single-cycle result; shifts deliberately use the raw A.
   always_comb begin
      op      = FS[4:2];
      as_s    = FS[0] ? ~A : A;
      bs_s    = FS[1] ? ~B : B;
      sh      = B[SW-1:0];
      sum_ext = {1'b0, as_s} + {1'b0, bs_s} + {{N{1'b0}}, C0};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_AND: alu_res = as_s & bs_s;
         OP_OR:  alu_res = as_s | bs_s;
         OP_XOR: alu_res = as_s ^ bs_s;
         OP_ADD: begin
            alu_res = sum_ext[N-1:0];
            alu_c   = sum_ext[N];
            alu_v   = ~(as_s[N-1] ^ bs_s[N-1]) & (sum_ext[N-1] ^ as_s[N-1]);
         end
         OP_LSL: alu_res = A << sh;
         OP_LSR: alu_res = A >> sh;
         OP_ASR: alu_res = $unsigned($signed(A) >>> sh);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      f_d      = f_q;
      status_d = status_q;
      done_d   = 1'b0;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  mcand_d  = as_s;
                  mplier_d = bs_s;
                  acc_d    = '0;
                  cnt_d    = '0;
               end else begin
                  f_d      = alu_res;
                  status_d = {alu_v, alu_c, alu_res[N-1], alu_res == '0};
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SW'(1);
            // Always N iterations: no early exit when the multiplier empties.
            if (cnt_q == CNT_LAST) begin
               f_d      = acc_step;
               status_d = {2'b00, acc_step[N-1], acc_step == '0};
               done_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_alu_seq_legv8.sv
// Self-checking bench for alu_seq_legv8: directed plan cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq_legv8;
   localparam int N  = 64;
   localparam int SW = 6;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         start;
   logic [N-1:0] a, b;
   logic [4:0]   fs;
   logic         c0;
   logic         busy, done;
   logic [N-1:0] f;
   logic [3:0]   status;

   int checks = 0;
   int passed = 0;

   always #5 clock = ~clock;

   alu_seq_legv8 #(.N(N)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .A       (a),
      .B       (b),
      .FS      (fs),
      .C0      (c0),
      .busy    (busy),
      .done    (done),
      .F       (f),
      .status  (status)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [N-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Returns {V,C,N,Z,F} computed from the operation's arithmetic meaning.
   function automatic logic [N+3:0] ref_op(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                           input logic [4:0] rfs, input logic rc0);
      logic [N-1:0]          as_v, bs_v, r;
      logic [2*N-1:0]        usum, prod, two_n;
      logic signed [2*N-1:0] ssum, smax, smin;
      logic                  v, c;
      int                    sh;
      as_v = rfs[0] ? ~ra : ra;
      bs_v = rfs[1] ? ~rb : rb;
      sh   = int'(rb[SW-1:0]);
      v = 1'b0;
      c = 1'b0;
      r = '0;
      two_n = '0;
      two_n[N] = 1'b1;
      smax = $signed({{(N+1){1'b0}}, {(N-1){1'b1}}});
      smin = -smax - 1;
      case (rfs[4:2])
         3'd0: r = as_v & bs_v;
         3'd1: r = as_v | bs_v;
         3'd2: r = as_v ^ bs_v;
         3'd3: begin
            usum = {{N{1'b0}}, as_v} + {{N{1'b0}}, bs_v} + {{(2*N-1){1'b0}}, rc0};
            r = usum[N-1:0];
            c = (usum >= two_n);
            ssum = $signed({{N{as_v[N-1]}}, as_v}) + $signed({{N{bs_v[N-1]}}, bs_v})
                 + $signed({{(2*N-1){1'b0}}, rc0});
            v = (ssum > smax) || (ssum < smin);
         end
         3'd4: r = ra << sh;
         3'd5: r = ra >> sh;
         3'd6: begin
            prod = {{N{1'b0}}, as_v} * {{N{1'b0}}, bs_v};
            r = prod[N-1:0];
         end
         default: begin
            r = ra >> sh;
            if (ra[N-1]) r = r | ~({N{1'b1}} >> sh);
         end
      endcase
      return {v, c, r[N-1], (r == '0), r};
   endfunction

   task automatic single_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [4:0] tfs,
                            input logic tc0, input logic [N-1:0] ef, input logic [3:0] es,
                            input string tag);
      @(negedge clock);
      a = ta; b = tb_v; fs = tfs; c0 = tc0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({tag, ".done"}, N'(done), N'(1));
      check({tag, ".busy"}, N'(busy), N'(0));
      check({tag, ".F"}, f, ef);
      check({tag, ".status"}, N'(status), N'(es));
   endtask

   task automatic mul_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [1:0] inv,
                         input logic [N-1:0] ef, input logic [3:0] es, input logic poke,
                         input string tag);
      int n, busy_cycles, overlap, extra;
      @(negedge clock);
      a = ta; b = tb_v; fs = {3'b110, inv}; c0 = 1'b0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({tag, ".busy_after_start"}, N'(busy), N'(1));
      check({tag, ".no_done_at_start"}, N'(done), N'(0));
      n = 0; busy_cycles = 0; overlap = 0;
      while (!done && n < 4 * N) begin
         if (busy) busy_cycles++;
         a = rand64(); b = rand64(); c0 = 1'($urandom);
         start = (poke && n == 10);
         @(negedge clock);
         n++;
         if (done && busy) overlap++;
      end
      start = 1'b0;
      check({tag, ".latency"}, N'(n), N'(N));
      check({tag, ".busy_cycles"}, N'(busy_cycles), N'(N));
      check({tag, ".done_busy_overlap"}, N'(overlap), N'(0));
      check({tag, ".F"}, f, ef);
      check({tag, ".status"}, N'(status), N'(es));
      extra = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) extra++;
      end
      check({tag, ".single_done"}, N'(extra), N'(0));
   endtask

   initial begin
      logic [N+3:0] exp_v;
      logic [N-1:0] ra, rb;
      logic [4:0]   rfs;
      logic         rc0;
      int           dones;

      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; fs = '0; c0 = 1'b0;
      repeat (3) @(negedge clock);
      check("reset.F", f, '0);
      check("reset.status", N'(status), N'(0));
      check("reset.busy", N'(busy), N'(0));
      check("reset.done", N'(done), N'(0));
      reset_n = 1'b1;

      single_op(64'd5, 64'd7, 5'b01110, 1'b1, 64'hFFFFFFFFFFFFFFFE, 4'b0010, "sub");
      @(negedge clock);
      check("sub.done_one_cycle", N'(done), N'(0));
      check("sub.F_hold", f, 64'hFFFFFFFFFFFFFFFE);
      single_op(64'h7FFFFFFFFFFFFFFF, 64'd1, 5'b01100, 1'b0, 64'h8000000000000000, 4'b1010, "ovf");
      single_op(64'hFFFFFFFFFFFFFFFF, 64'd1, 5'b01100, 1'b0, 64'h0, 4'b0101, "carry_zero");
      single_op(64'h8000000000000000, 64'd4, 5'b11100, 1'b0, 64'hF800000000000000, 4'b0010, "asr");
      single_op(64'h8000000000000000, 64'd4, 5'b10100, 1'b0, 64'h0800000000000000, 4'b0000, "lsr");

      // Back-to-back starts on consecutive edges.
      @(negedge clock);
      a = 64'hF0; b = 64'h0F; fs = 5'b00100; c0 = 1'b0; start = 1'b1;
      @(negedge clock);
      check("b2b.first.F", f, 64'hFF);
      check("b2b.first.done", N'(done), N'(1));
      a = 64'h1; b = 64'd63; fs = 5'b10000;
      @(negedge clock);
      start = 1'b0;
      check("b2b.second.F", f, 64'h8000000000000000);
      check("b2b.second.done", N'(done), N'(1));

      mul_op(64'd12345, 64'd678, 2'b00, 64'd8369910, 4'b0000, 1'b0, "mul");
      mul_op(64'hFFFFFFFFFFFFFFFF, 64'd3, 2'b00, 64'hFFFFFFFFFFFFFFFD, 4'b0010, 1'b1, "mul_wrap");

      for (int i = 0; i < 40; i++) begin
         ra = rand64(); rb = rand64(); rfs = 5'($urandom); rc0 = 1'($urandom);
         if ($urandom_range(0, 3) == 0) rb = {{(N-SW){1'b0}}, rb[SW-1:0]};
         exp_v = ref_op(ra, rb, rfs, rc0);
         if (rfs[4:2] == 3'b110)
            mul_op(ra, rb, rfs[1:0], exp_v[N-1:0], exp_v[N+3:N], 1'b0, $sformatf("rnd%0d.mul", i));
         else
            single_op(ra, rb, rfs, rc0, exp_v[N-1:0], exp_v[N+3:N], $sformatf("rnd%0d.op%0d", i, rfs[4:2]));
      end

      // Reset in the middle of a multiply.
      @(negedge clock);
      a = 64'd99; b = 64'd77; fs = 5'b11000; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (29) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("rst_mid.F", f, '0);
      check("rst_mid.status", N'(status), N'(0));
      check("rst_mid.busy", N'(busy), N'(0));
      check("rst_mid.done", N'(done), N'(0));
      @(negedge clock);
      reset_n = 1'b1;
      dones = 0;
      repeat (100) begin
         @(negedge clock);
         if (done || busy) dones++;
      end
      check("rst_mid.no_done_after", N'(dones), N'(0));
      single_op(64'hF0, 64'h3C, 5'b00000, 1'b0, 64'h30, 4'b0000, "and_after_rst");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
